gf2m_mult_sequencer: RTL and testbench
======================================

# gf2m_mult_sequencer

Control and operand-feeding stage that sits directly upstream of the GF(2^m) bit-parallel systolic multiplier array, with the result capture on the array's output side. It accepts one (A, B, F) operand set through a valid/ready handshake and clears the array. It then drives the array's load select, operand buses and serial B bits for M cycles. Finally it captures the array's c outputs and presents the product through a valid/ready output handshake.

## Interface
- M, 8: field degree; width of A, B, F, C; M ≥ 2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  sequencer can accept operands
- a_in  in  M  multiplicand A, bit j = coefficient of x^j
- b_in  in  M  multiplier B, bit j = coefficient of x^j
- f_in  in  M  reduction polynomial low terms f_0..f_{M-1}; x^M is implicit
- arr_clr  out  1  one-cycle synchronous clear of array accumulators
- arr_sel  out  1  array load select, 1 = load operands into the first row
- arr_a  out  M  registered A to array (a_j inputs)
- arr_f  out  M  registered F to array (f_j inputs)
- arr_b  out  1  current serial B bit, MSB first
- c_in  in  M  array c_j outputs
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_c  out  M  product C = A·B mod F

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, HOLD. The state resets to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, register a_in, b_in and f_in, then go to CLEAR.
- CLEAR:
  - arr_clr=1 for exactly one cycle.
  - Clear the bit counter k to 0, then go to RUN.
- RUN lasts M cycles, k=0..M-1:
  - arr_b = b_reg[M-1-k].
  - arr_sel=1 only when k=0, else 0.
  - k increments each cycle. After k=M-1, go to DRAIN.
- DRAIN:
  - One cycle that covers the array's one-register output latency.
  - arr_b=0, arr_sel=0.
  - At the end of the cycle, capture c_in into out_c and go to HOLD.
- HOLD:
  - out_valid=1.
  - out_c stays stable until out_valid && out_ready, then go to IDLE.
- arr_a and arr_f always equal the registered operands. They change only on an accepted input.
- in_ready=0 in every state except IDLE. in_valid is ignored outside IDLE.
- k is $clog2(M) bits wide. It never wraps within RUN; the exit is at k==M-1.
- Reset asserted mid-operation (any state):
  - Return to IDLE and discard the current operation. Nothing is emitted.
  - The array is cleared by the same reset.

## Timing
- Reset values: in_ready=0 while reset is asserted, then 1 in IDLE. arr_clr, arr_sel, arr_b, out_valid = 0. arr_a, arr_f, out_c = 0.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Accept at edge T gives:
  - CLEAR during cycle T+1
  - RUN during T+2..T+M+1
  - DRAIN at T+M+2
  - out_valid from T+M+3
- Latency from accept to out_valid is M+3 cycles; M=8 gives 11.
- Throughput is one product per M+4 cycles minimum, when out_ready is held at 1.
- Output handshake: the transfer happens on an edge with out_valid && out_ready. Under backpressure, out_valid stays 1 and out_c is held.
- Earliest next accept is the cycle after the output transfer.

## Test plan
- Reset, then release; hold in_valid=0. Required: in_ready=1, out_valid=0, arr_clr/arr_sel/arr_b = 0, out_c=0.
- M=8, A=0x57, B=0x83, F=0x1B, with a behavioural array model. Required:
  - arr_clr pulses once.
  - arr_b sequence is 1,0,0,0,0,0,1,1.
  - arr_sel=1 only in the first RUN cycle.
  - out_valid rises 11 cycles after accept with out_c=0xC1.
- Same operands, out_ready=0 for 5 cycles after out_valid. Required:
  - out_c=0xC1 held and out_valid stays 1.
  - in_ready stays 0, and a new in_valid with other operands is ignored.
  - Transfer completes when out_ready=1.
- Back-to-back: A=0x02, B=0x80, F=0x1B, then A=0xFF, B=0x01. Required:
  - Products 0x1B then 0xFF.
  - Second accept lands one cycle after the first output transfer.
- Assert reset during RUN at k=4. Required:
  - All outputs return to reset values immediately, and no out_valid appears.
  - Next operation A=0x57, B=0x83 yields 0xC1.
- B=0x00, A=0xFF. Required:
  - arr_b=0 for all 8 RUN cycles.
  - out_c=0x00, and the latency is unchanged at 11.

Source files
------------

// File: rtl/gf2m_mult_sequencer.sv
// gf2m_mult_sequencer: operand feed, control and result capture for a GF(2^m)
// bit-parallel systolic multiplier array, with valid/ready on both sides.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   i_in_valid        operand set valid       o_in_ready   can accept operands
//   i_a_in / i_b_in   multiplicand / multiplier, bit j = coeff of x^j
//   i_f_in            reduction polynomial f_0..f_{M-1} (x^M implicit)
//   o_arr_clr         one-cycle clear of the array accumulators
//   o_arr_sel         array load select (first RUN cycle only)
//   o_arr_a / o_arr_f registered operands to the array
//   o_arr_b           serial B bit, MSB first
//   i_c_in            array c outputs
//   o_out_valid       product valid           i_out_ready  consumer accepts
//   o_out_c           product C = A*B mod F
module gf2m_mult_sequencer #(
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [M-1:0] i_a_in,
    input  logic [M-1:0] i_b_in,
    input  logic [M-1:0] i_f_in,
    output logic         o_arr_clr,
    output logic         o_arr_sel,
    output logic [M-1:0] o_arr_a,
    output logic [M-1:0] o_arr_f,
    output logic         o_arr_b,
    input  logic [M-1:0] i_c_in,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [M-1:0] o_out_c
);

    localparam int KW = $clog2(M);
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [M-1:0]    r_a;
    logic [M-1:0]    r_f;
    logic [M-1:0]    r_bsh;
    logic [M-1:0]    r_c;
    logic            r_in_ready;
    logic            r_clr;
    logic            r_sel;
    logic            r_b;
    logic            r_out_valid;
    logic            w_accept;

    // r_in_ready is low during reset and rises on the first edge after it,
    // so accepting on r_in_ready never races the reset release.
    assign w_accept = r_in_ready && i_in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_a         <= '0;
            r_f         <= '0;
            r_bsh       <= '0;
            r_c         <= '0;
            r_in_ready  <= 1'b0;
            r_clr       <= 1'b0;
            r_sel       <= 1'b0;
            r_b         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= i_a_in;
                        r_f        <= i_f_in;
                        r_bsh      <= i_b_in;
                        r_in_ready <= 1'b0;
                        r_clr      <= 1'b1;
                        r_state    <= CLEAR;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Outputs for RUN k=0 are set up here so they are
                    // registered: load select plus the B MSB.
                    r_clr   <= 1'b0;
                    r_k     <= '0;
                    r_sel   <= 1'b1;
                    r_b     <= r_bsh[M-1];
                    r_bsh   <= r_bsh << 1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_sel <= 1'b0;
                    if (r_k == K_LAST) begin
                        r_b     <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_k   <= r_k + 1'b1;
                        r_b   <= r_bsh[M-1];
                        r_bsh <= r_bsh << 1;
                    end
                end
                DRAIN: begin
                    r_c         <= i_c_in;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_arr_clr   = r_clr;
    assign o_arr_sel   = r_sel;
    assign o_arr_a     = r_a;
    assign o_arr_f     = r_f;
    assign o_arr_b     = r_b;
    assign o_out_valid = r_out_valid;
    assign o_out_c     = r_c;

endmodule

// File: tb/tb_gf2m_mult_sequencer.sv
// tb_gf2m_mult_sequencer: directed bench for gf2m_mult_sequencer with a
// behavioural serial-MSB-first array model on the array side.
module tb_gf2m_mult_sequencer;

    localparam int M = 8;

    logic         clk;
    logic         reset;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [M-1:0] i_a_in;
    logic [M-1:0] i_b_in;
    logic [M-1:0] i_f_in;
    logic         o_arr_clr;
    logic         o_arr_sel;
    logic [M-1:0] o_arr_a;
    logic [M-1:0] o_arr_f;
    logic         o_arr_b;
    logic [M-1:0] w_c;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [M-1:0] o_out_c;

    int checks;
    int errors;

    gf2m_mult_sequencer #(.M(M)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a_in      (i_a_in),
        .i_b_in      (i_b_in),
        .i_f_in      (i_f_in),
        .o_arr_clr   (o_arr_clr),
        .o_arr_sel   (o_arr_sel),
        .o_arr_a     (o_arr_a),
        .o_arr_f     (o_arr_f),
        .o_arr_b     (o_arr_b),
        .i_c_in      (w_c),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_c     (o_out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: accumulator register, Horner step c = c*x + b*A mod F.
    logic [M-1:0] acc;
    function automatic logic [M-1:0] xt(input logic [M-1:0] v,
                                        input logic [M-1:0] f);
        xt = {v[M-2:0], 1'b0} ^ (v[M-1] ? f : '0);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else if (o_arr_clr) acc <= '0;
        else if (o_arr_sel) acc <= o_arr_b ? o_arr_a : '0;
        else acc <= xt(acc, o_arr_f) ^ (o_arr_b ? o_arr_a : '0);
    end
    assign w_c = acc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with in_ready expected high; returns at the
    // negedge right after the output transfer.
    task automatic do_op(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] f,
                         input logic [7:0] exp_c, input int stall);
        int lat;
        int clr_n;
        int sel_n;
        int sel_at;
        logic [7:0] bseq;
        chk({tag, "_rdy"}, o_in_ready, 1);
        i_in_valid = 1'b1;
        i_a_in = a;
        i_b_in = b;
        i_f_in = f;
        @(negedge clk);
        i_in_valid = 1'b0;
        i_a_in = 8'hAA;
        i_b_in = 8'hAA;
        lat = 1; clr_n = 0; sel_n = 0; sel_at = 0; bseq = '0;
        while (!o_out_valid && lat < 20) begin
            if (o_arr_clr) clr_n++;
            if (o_arr_sel) begin sel_n++; sel_at = lat; end
            if (lat >= 2 && lat <= 9) bseq = {bseq[6:0], o_arr_b};
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 11);
        chk({tag, "_clr"}, clr_n, 1);
        chk({tag, "_sel"}, {sel_n[15:0], sel_at[15:0]}, {16'd1, 16'd2});
        chk({tag, "_bseq"}, bseq, b);
        chk({tag, "_a"}, o_arr_a, a);
        chk({tag, "_c"}, o_out_c, exp_c);
        for (int i = 0; i < stall; i++) begin
            i_in_valid = 1'b1;
            i_a_in = 8'h11;
            i_b_in = 8'h22;
            @(negedge clk);
            chk({tag, "_hv"}, {o_out_valid, o_in_ready}, 2'b10);
            chk({tag, "_hc"}, o_out_c, exp_c);
        end
        if (stall > 0) chk({tag, "_ha"}, o_arr_a, a);
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        chk({tag, "_xfer"}, {o_out_valid, o_in_ready}, 2'b01);
    endtask

    initial begin
        int k;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        i_in_valid = 1'b0;
        i_out_ready = 1'b0;
        i_a_in = '0;
        i_b_in = '0;
        i_f_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy", o_in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outs", {o_in_ready, o_out_valid, o_arr_clr, o_arr_sel,
                         o_arr_b}, 5'b10000);
        chk("rst_data", {o_out_c, o_arr_a, o_arr_f}, 24'h0);

        do_op("basic", 8'h57, 8'h83, 8'h1B, 8'hC1, 0);
        do_op("stall", 8'h57, 8'h83, 8'h1B, 8'hC1, 5);
        do_op("b2b1", 8'h02, 8'h80, 8'h1B, 8'h1B, 0);
        do_op("b2b2", 8'hFF, 8'h01, 8'h1B, 8'hFF, 0);

        // Reset during RUN with k=4 (RUN k=0 is the 2nd cycle after accept).
        i_in_valid = 1'b1;
        i_a_in = 8'h57;
        i_b_in = 8'h83;
        i_f_in = 8'h1B;
        @(negedge clk);
        i_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("mid_run", {o_arr_sel, o_out_valid, o_in_ready}, 3'b000);
        reset = 1'b1;
        #1;
        chk("mid_rst", {o_in_ready, o_out_valid, o_arr_clr, o_arr_sel,
                        o_arr_b}, 5'b00000);
        chk("mid_data", {o_out_c, o_arr_a, o_arr_f}, 24'h0);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (o_out_valid) k++;
        end
        chk("mid_noval", k, 0);
        do_op("after", 8'h57, 8'h83, 8'h1B, 8'hC1, 0);

        do_op("bzero", 8'hFF, 8'h00, 8'h1B, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
